// File: rtl/key_pkg.sv
// Shared definitions for the key input/output blocks: FSM state encoding
// and the blink-count width.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2,
      RSVD = 2'd3
   } blink_state_t;

   localparam int BLINK_W = 4;

endpackage

// File: rtl/phase_counter.sv
// Phase length counter: counts enabled cycles and returns to zero on its own
// when it reaches limit-1, flagging that cycle on tc.
module phase_counter #(
   parameter int CNT_W = 20
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             tc
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_reg;

   assign tc = (cnt_reg == (limit - CNT_ONE));

   // Returning to zero on terminal count keeps cnt below the active limit,
   // so it can never wrap even when the limit switches between phases.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt_reg <= '0;
      end else if (clear) begin
         cnt_reg <= '0;
      end else if (enable) begin
         if (tc) begin
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/key_blink_driver.sv
// Turns a single-cycle trigger into blink_num on/off LED periods, with
// registered led/busy outputs and a one-cycle done pulse at the end.
module key_blink_driver
   import key_pkg::*;
#(
   parameter int ON_CNT  = 25_000,
   parameter int OFF_CNT = 25_000,
   parameter int CNT_W   = 20
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               trigger,
   input  logic [BLINK_W-1:0] blink_num,
   output logic               led,
   output logic               busy,
   output logic               done
);

   localparam logic [CNT_W-1:0]   ON_LIMIT  = CNT_W'(ON_CNT);
   localparam logic [CNT_W-1:0]   OFF_LIMIT = CNT_W'(OFF_CNT);
   localparam logic [BLINK_W-1:0] REM_ONE   = BLINK_W'(1);

   blink_state_t       state_reg;
   logic [BLINK_W-1:0] rem_reg;
   logic               led_reg;
   logic               busy_reg;
   logic               done_reg;

   logic               cnt_clear;
   logic               cnt_enable;
   logic [CNT_W-1:0]   cnt_limit;
   logic               cnt_tc;

   // Counter sits at zero outside a sequence, so an accepted trigger
   // always starts the ON phase from a clean count.
   assign cnt_enable = (state_reg == ON) || (state_reg == OFF);
   assign cnt_clear  = !cnt_enable;
   assign cnt_limit  = (state_reg == ON) ? ON_LIMIT : OFF_LIMIT;

   phase_counter #(
      .CNT_W (CNT_W)
   ) u_phase_counter (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .clear   (cnt_clear),
      .enable  (cnt_enable),
      .limit   (cnt_limit),
      .tc      (cnt_tc)
   );

   // led/busy are loaded with the decode of the next state so they track
   // state_reg exactly while coming straight from flops.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_reg <= IDLE;
         rem_reg   <= '0;
         led_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (trigger && (blink_num != '0)) begin
                  rem_reg   <= blink_num;
                  state_reg <= ON;
                  led_reg   <= 1'b1;
                  busy_reg  <= 1'b1;
               end
            end
            ON: begin
               if (cnt_tc) begin
                  state_reg <= OFF;
                  led_reg   <= 1'b0;
               end
            end
            OFF: begin
               if (cnt_tc) begin
                  if (rem_reg > REM_ONE) begin
                     rem_reg   <= rem_reg - REM_ONE;
                     state_reg <= ON;
                     led_reg   <= 1'b1;
                  end else begin
                     rem_reg   <= '0;
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                  end
               end
            end
            default: begin
               // Unused encoding behaves as IDLE for one cycle, then recovers.
               state_reg <= IDLE;
               rem_reg   <= '0;
               led_reg   <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign led  = led_reg;
   assign busy = busy_reg;
   assign done = done_reg;

endmodule
